// File: rtl/decim_iq_core.sv
// Integer-factor IQ decimator: boxcar-sums D samples per channel, scales by an
// arithmetic right shift, saturates, and emits one I/Q pair per D inputs.

// One channel of the decimator: accumulator, shifter and clamp.
module decim_iq_lane #(
  parameter int DW = 12,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_en,
  input  logic                 first,
  input  logic                 emit,
  input  logic [4:0]           shift,
  input  logic signed [DW-1:0] sample,
  output logic signed [DW-1:0] result,
  output logic                 clamp
);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (DW-1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [AW-1:0] acc, ext, sum, scaled;

  // First sample of a block reloads the sum; later samples accumulate.
  always_comb begin
    ext    = {{(AW-DW){sample[DW-1]}}, sample};
    sum    = first ? ext : acc + ext;
    scaled = sum >>> shift;
    clamp  = (scaled > MAXV) || (scaled < MINV);
  end

  // Accumulator and held result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (acc_en) acc <= sum;
      if (emit) begin
        if (scaled > MAXV)      result <= MAXV[DW-1:0];
        else if (scaled < MINV) result <= MINV[DW-1:0];
        else                    result <= scaled[DW-1:0];
      end
    end
  end
endmodule

module decim_iq_core #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int DATAPATH_WIDTH = 12,
  parameter int ACC_BITS       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             Empty_i,
  input  logic                             Afull_i,
  input  logic [4*CONFIG_WIDTH-1:0]        config_reg,
  input  logic signed [DATAPATH_WIDTH-1:0] data_in_from_fifo_I,
  input  logic signed [DATAPATH_WIDTH-1:0] data_in_from_fifo_Q,
  output logic                             Read_Enable_fifo,
  output logic                             Write_Enable_fifo,
  output logic [7:0]                       status_reg,
  output logic signed [DATAPATH_WIDTH-1:0] I_dec,
  output logic signed [DATAPATH_WIDTH-1:0] Q_dec
);
  localparam int NUM_LANES = 2;
  localparam int DW = DATAPATH_WIDTH;
  localparam int AW = DATAPATH_WIDTH + ACC_BITS;
  localparam int CW = CONFIG_WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, ACC, OUT, DONE} state_t;

  typedef struct packed {
    logic                bypass;
    logic [ACC_BITS-1:0] d_m1;   // D-1; iD==0 wraps to all ones, i.e. D=2^ACC_BITS
    logic [4:0]          shift;
    logic [CW-1:0]       olen;
  } cfg_t;

  state_t                        state, state_n;
  cfg_t                          cfg;
  logic [ACC_BITS-1:0]           cnt;
  logic [CW-1:0]                 out_cnt;
  logic                          done, sat, last, start_ok;
  logic [NUM_LANES-1:0][DW-1:0]  lane_in, lane_out;
  logic [NUM_LANES-1:0]          lane_clamp;

  assign start_ok = (state == IDLE) && start;
  assign last     = (state == ACC) && (cnt == cfg.d_m1);
  assign lane_in  = {data_in_from_fifo_Q, data_in_from_fifo_I};

  // I and Q share every control strobe, so they can never diverge.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    decim_iq_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .acc_en (state == ACC),
      .first  (cnt == '0),
      .emit   (last),
      .shift  (cfg.shift),
      .sample (lane_in[g]),
      .result (lane_out[g]),
      .clamp  (lane_clamp[g])
    );
  end

  assign I_dec = lane_out[0];
  assign Q_dec = lane_out[1];

  // Next-state and strobe decode; strobes are gated by the stall flags.
  always_comb begin
    state_n           = state;
    Read_Enable_fifo  = 1'b0;
    Write_Enable_fifo = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (config_reg[3*CW +: CW] == '0) ? DONE : FETCH;
      FETCH: if (!Empty_i) begin
               Read_Enable_fifo = 1'b1;
               state_n          = ACC;
             end
      ACC:   state_n = last ? OUT : FETCH;
      OUT:   if (!Afull_i) begin
               Write_Enable_fifo = 1'b1;
               state_n           = (out_cnt == cfg.olen - CW'(1)) ? DONE : FETCH;
             end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, config latch, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cfg     <= '0;
      cnt     <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        cfg.bypass <= config_reg[0];
        cfg.d_m1   <= config_reg[0] ? '0 : config_reg[CW +: ACC_BITS] - ACC_BITS'(1);
        cfg.shift  <= config_reg[0] ? '0 : config_reg[2*CW +: 5];
        cfg.olen   <= config_reg[3*CW +: CW];
        cnt        <= '0;
        out_cnt    <= '0;
        done       <= 1'b0;
        sat        <= 1'b0;
      end
      if (state == ACC) cnt <= last ? '0 : cnt + ACC_BITS'(1);
      if (last && |lane_clamp) sat <= 1'b1;
      if (Write_Enable_fifo) out_cnt <= out_cnt + CW'(1);
      if (state != DONE && state_n == DONE) done <= 1'b1;
    end
  end

  assign status_reg = {1'b0, sat, cfg.bypass, 1'b0,
                       (state == OUT) && Afull_i,
                       (state == FETCH) && Empty_i,
                       (state == FETCH) || (state == ACC) || (state == OUT),
                       done};
endmodule

// File: tb/tb_decim_iq_core.sv
// Directed bench for decim_iq_core: a cycle-stepped FIFO model feeds samples
// one cycle after each read strobe, and strobes/status are logged per cycle.
module tb_decim_iq_core;
  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0, Empty_i = 1'b0, Afull_i = 1'b0;
  logic [127:0]         config_reg = '0;
  logic signed [DW-1:0] di = '0, dq = '0;
  logic                 re, we;
  logic [7:0]           status_reg;
  logic signed [DW-1:0] I_dec, Q_dec;

  decim_iq_core dut (
    .clk(clk), .rst(rst), .start(start), .Empty_i(Empty_i), .Afull_i(Afull_i),
    .config_reg(config_reg), .data_in_from_fifo_I(di), .data_in_from_fifo_Q(dq),
    .Read_Enable_fifo(re), .Write_Enable_fifo(we), .status_reg(status_reg),
    .I_dec(I_dec), .Q_dec(Q_dec)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic signed [DW-1:0] src_i [0:255];
  logic signed [DW-1:0] src_q [0:255];
  logic signed [DW-1:0] wr_i [0:15];
  logic signed [DW-1:0] wr_q [0:15];
  logic [7:0]  st_log [0:1023];
  logic [63:0] re_mask, we_mask;
  int rd_ptr, nwr, proto_err;
  int empty_lo = 0, empty_hi = -1, afull_lo = 0, afull_hi = -1;

  // Start a run with the given config and step ncyc cycles after the start edge.
  task automatic run(input bit byp, input int id, input int sh, input int olen, input int ncyc);
    bit r;
    config_reg = {32'(olen), 32'(sh), 32'(id), 31'd0, byp};
    rd_ptr = 0; nwr = 0; proto_err = 0; re_mask = '0; we_mask = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      Empty_i = (c >= empty_lo) && (c <= empty_hi);
      Afull_i = (c >= afull_lo) && (c <= afull_hi);
      @(negedge clk);
      r = re;
      if (c < 64) begin re_mask[c] = re; we_mask[c] = we; end
      if (c < 1024) st_log[c] = status_reg;
      if ((re && we) || (re && Empty_i) || (we && Afull_i)) proto_err++;
      if (we && nwr < 16) begin wr_i[nwr] = I_dec; wr_q[nwr] = Q_dec; nwr++; end
      @(posedge clk); #1;
      if (r && rd_ptr < 256) begin di = src_i[rd_ptr]; dq = src_q[rd_ptr]; rd_ptr++; end
    end
    Empty_i = 1'b0; Afull_i = 1'b0;
    empty_lo = 0; empty_hi = -1; afull_lo = 0; afull_hi = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'($urandom); Empty_i = 1'($urandom); Afull_i = 1'($urandom);
      config_reg = {$urandom, $urandom, $urandom, $urandom};
      di = DW'($urandom); dq = DW'($urandom);
      @(negedge clk);
      n_tests++;
      if ({re, we, status_reg, I_dec, Q_dec} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: re=%b we=%b st=%h I=%0d Q=%0d want all 0", k, re, we, status_reg, I_dec, Q_dec);
      end
    end
    start = 1'b0; Empty_i = 1'b0; Afull_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic load_basic();
    for (int k = 0; k < 4; k++) begin src_i[k] = DW'(100 + 4*k); src_q[k] = -12'sd4; end
  endtask

  task automatic test_basic();
    load_basic();
    run(0, 4, 2, 1, 12);
    n_tests++; if (re_mask !== 64'hAA) begin n_fail++; $display("FAIL basic_re_cycles: got %h want %h", re_mask, 64'hAA); end
    n_tests++; if (we_mask !== 64'h200) begin n_fail++; $display("FAIL basic_we_cycles: got %h want %h", we_mask, 64'h200); end
    n_tests++; if (nwr !== 1 || wr_i[0] !== 12'sd106 || wr_q[0] !== -12'sd4) begin n_fail++; $display("FAIL basic_result: n=%0d I=%0d Q=%0d want 1 106 -4", nwr, wr_i[0], wr_q[0]); end
    n_tests++; if (st_log[1] !== 8'h02) begin n_fail++; $display("FAIL basic_busy: got %h want 02", st_log[1]); end
    n_tests++; if (st_log[10] !== 8'h01) begin n_fail++; $display("FAIL basic_done_status: got %h want 01", st_log[10]); end
    n_tests++; if (proto_err !== 0) begin n_fail++; $display("FAIL basic_protocol: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 8; k++) begin src_i[k] = (k < 4) ? 12'sd2047 : -12'sd2048; src_q[k] = '0; end
    run(0, 4, 0, 2, 20);
    n_tests++; if (nwr !== 2 || wr_i[0] !== 12'sd2047 || wr_i[1] !== -12'sd2048) begin n_fail++; $display("FAIL sat_values: n=%0d I0=%0d I1=%0d want 2 2047 -2048", nwr, wr_i[0], wr_i[1]); end
    n_tests++; if (status_reg[6] !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", status_reg[6]); end
    n_tests++; if (status_reg[1:0] !== 2'b01) begin n_fail++; $display("FAIL sat_done: got %b want 01", status_reg[1:0]); end
  endtask

  task automatic test_empty_stall();
    int se;
    load_basic();
    empty_lo = 3; empty_hi = 7;
    run(0, 4, 2, 1, 16);
    se = 0;
    for (int c = 3; c <= 7; c++) if (st_log[c][2]) se++;
    n_tests++; if (se !== 5 || st_log[8][2] !== 1'b0) begin n_fail++; $display("FAIL empty_stop_flag: got %0d cycles (cyc8=%b) want 5 (0)", se, st_log[8][2]); end
    n_tests++; if (re_mask !== 64'h1502 || we_mask !== 64'h4000) begin n_fail++; $display("FAIL empty_strobes: re=%h we=%h want 1502 4000", re_mask, we_mask); end
    n_tests++; if (nwr !== 1 || wr_i[0] !== 12'sd106 || wr_q[0] !== -12'sd4) begin n_fail++; $display("FAIL empty_result: n=%0d I=%0d Q=%0d want 1 106 -4", nwr, wr_i[0], wr_q[0]); end
    n_tests++; if (status_reg[6] !== 1'b0 || proto_err !== 0) begin n_fail++; $display("FAIL empty_sat_clear: sat=%b proto=%0d want 0 0", status_reg[6], proto_err); end
  endtask

  task automatic test_afull_stall();
    int sa;
    load_basic();
    afull_lo = 9; afull_hi = 12;
    run(0, 4, 2, 1, 15);
    sa = 0;
    for (int c = 9; c <= 12; c++) if (st_log[c][3]) sa++;
    n_tests++; if (sa !== 4) begin n_fail++; $display("FAIL afull_stop_flag: got %0d cycles want 4", sa); end
    n_tests++; if (we_mask !== 64'h2000 || proto_err !== 0) begin n_fail++; $display("FAIL afull_we_cycle: got %h proto=%0d want 2000 0", we_mask, proto_err); end
    n_tests++; if (nwr !== 1 || wr_i[0] !== 12'sd106 || wr_q[0] !== -12'sd4) begin n_fail++; $display("FAIL afull_result: n=%0d I=%0d Q=%0d want 1 106 -4", nwr, wr_i[0], wr_q[0]); end
  endtask

  task automatic test_round_floor();
    src_i[0] = 12'sd3;  src_i[1] = 12'sd0;
    src_q[0] = -12'sd3; src_q[1] = 12'sd0;
    run(0, 2, 1, 1, 8);
    n_tests++; if (nwr !== 1 || wr_i[0] !== 12'sd1 || wr_q[0] !== -12'sd2) begin n_fail++; $display("FAIL round_floor: n=%0d I=%0d Q=%0d want 1 1 -2", nwr, wr_i[0], wr_q[0]); end
  endtask

  task automatic test_bypass();
    src_i[0] = 12'sd5; src_i[1] = -12'sd7; src_i[2] = 12'sd300;
    src_q[0] = 12'sd1; src_q[1] = 12'sd2;  src_q[2] = -12'sd3;
    run(1, 4, 3, 3, 11);
    n_tests++; if (re_mask !== 64'h92 || we_mask !== 64'h248) begin n_fail++; $display("FAIL bypass_strobes: re=%h we=%h want 92 248", re_mask, we_mask); end
    n_tests++; if (nwr !== 3 || wr_i[0] !== 12'sd5 || wr_i[1] !== -12'sd7 || wr_i[2] !== 12'sd300) begin n_fail++; $display("FAIL bypass_I: n=%0d %0d %0d %0d want 3 5 -7 300", nwr, wr_i[0], wr_i[1], wr_i[2]); end
    n_tests++; if (wr_q[0] !== 12'sd1 || wr_q[1] !== 12'sd2 || wr_q[2] !== -12'sd3) begin n_fail++; $display("FAIL bypass_Q: %0d %0d %0d want 1 2 -3", wr_q[0], wr_q[1], wr_q[2]); end
    n_tests++; if (st_log[1] !== 8'h22 || status_reg !== 8'h21) begin n_fail++; $display("FAIL bypass_status: run=%h end=%h want 22 21", st_log[1], status_reg); end
  endtask

  task automatic test_olen_zero();
    run(0, 4, 0, 0, 3);
    n_tests++; if (re_mask !== '0 || we_mask !== '0) begin n_fail++; $display("FAIL olen0_strobes: re=%h we=%h want 0 0", re_mask, we_mask); end
    n_tests++; if (st_log[1] !== 8'h01 || st_log[2] !== 8'h01) begin n_fail++; $display("FAIL olen0_done: %h %h want 01 01", st_log[1], st_log[2]); end
  endtask

  task automatic test_max_factor();
    for (int k = 0; k < 256; k++) begin src_i[k] = 12'sd3; src_q[k] = -12'sd3; end
    run(0, 0, 8, 1, 516);
    n_tests++; if (rd_ptr !== 256 || nwr !== 1) begin n_fail++; $display("FAIL dmax_counts: reads=%0d writes=%0d want 256 1", rd_ptr, nwr); end
    n_tests++; if (wr_i[0] !== 12'sd3 || wr_q[0] !== -12'sd3 || status_reg !== 8'h01) begin n_fail++; $display("FAIL dmax_result: I=%0d Q=%0d st=%h want 3 -3 01", wr_i[0], wr_q[0], status_reg); end
  endtask

  task automatic test_abort();
    int strobes;
    load_basic();
    run(0, 4, 2, 1, 4);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (re || we) strobes++;
    end
    n_tests++; if (strobes !== 0) begin n_fail++; $display("FAIL abort_strobes: got %0d want 0", strobes); end
    n_tests++; if (status_reg !== 8'h00 || I_dec !== 12'sd0 || Q_dec !== 12'sd0) begin n_fail++; $display("FAIL abort_state: st=%h I=%0d Q=%0d want 00 0 0", status_reg, I_dec, Q_dec); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_empty_stall();
    test_afull_stall();
    test_round_floor();
    test_bypass();
    test_olen_zero();
    test_max_factor();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
